microsequencer: RTL and testbench

//  Microprogram address sequencer for the control unit. Holds the micro-PC (uPC), which drives

---
 rtl/microsequencer.sv | 148 ++++++++++++++
 tb/tb_microsequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/microsequencer.sv
// Microprogram address sequencer: holds the micro-PC and picks the next
// control-store address from the sequencing fields of the current word.
// It also contains a small return-address stack for microsubroutines and
// a watchdog that stops a memory wait from hanging the control unit.
module microsequencer #(
   parameter int             AW          = 10,
   parameter int             STACK_DEPTH = 4,
   parameter logic [AW-1:0]  FETCH_STATE = '0,
   parameter logic [AW-1:0]  FAULT_STATE = AW'(255),
   parameter int             WAIT_LIMIT  = 15
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [2:0]    nsel,
   input  logic [1:0]    cond_sel,
   input  logic          cond_inv,
   input  logic [AW-1:0] cr_addr,
   input  logic [AW-1:0] decode_addr,
   input  logic [3:0]    flags,
   input  logic          mem_done,
   output logic [AW-1:0] next_state,
   output logic          mem_wait,
   output logic [2:0]    stack_depth,
   output logic          fault
);

   // The stack_depth port is three bits wide, so STACK_DEPTH is at most 7.
   localparam int SW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam int CW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
   localparam logic [2:0]    DEPTH_MAX = 3'(STACK_DEPTH);
   localparam logic [CW-1:0] CNT_MAX   = CW'(WAIT_LIMIT);

   typedef enum logic [2:0] {
      SEQ_INC      = 3'd0,
      SEQ_JUMP     = 3'd1,
      SEQ_BRANCH   = 3'd2,
      SEQ_DECODE   = 3'd3,
      SEQ_CALL     = 3'd4,
      SEQ_RET      = 3'd5,
      SEQ_WAIT_MEM = 3'd6,
      SEQ_FETCH    = 3'd7
   } seq_op_e;

   seq_op_e       op;
   logic [AW-1:0] upc_q, upc_d, upc_inc;
   logic [2:0]    depth_q, depth_d;
   logic [CW-1:0] wait_cnt_q, wait_cnt_d;
   logic          fault_q, fault_d;
   logic          push_en;
   logic [SW-1:0] push_idx, top_idx;
   logic [AW-1:0] stack_mem [STACK_DEPTH];
   logic          flag_sel, cond;
   logic          unused_v_flag;

   assign op            = seq_op_e'(nsel);
   assign upc_inc       = upc_q + AW'(1);
   assign push_idx      = depth_q[SW-1:0];
   assign top_idx       = SW'(depth_q - 3'd1);
   assign cond          = flag_sel ^ cond_inv;
   assign unused_v_flag = flags[3];

   assign next_state  = upc_q;
   assign stack_depth = depth_q;
   assign fault       = fault_q;
   assign mem_wait    = (op == SEQ_WAIT_MEM) && !mem_done;

   // Pick the branch condition; select 0 means "always true".
   always_comb begin
      flag_sel = 1'b1;
      case (cond_sel)
         2'd0: flag_sel = 1'b1;
         2'd1: flag_sel = flags[0];
         2'd2: flag_sel = flags[1];
         2'd3: flag_sel = flags[2];
         default: flag_sel = 1'b1;
      endcase
   end

   // Next-address selection, stack bookkeeping and fault detection.
   // A fault leaves the stack untouched and diverts to FAULT_STATE.
   always_comb begin
      upc_d      = upc_q;
      depth_d    = depth_q;
      wait_cnt_d = '0;
      fault_d    = fault_q;
      push_en    = 1'b0;
      case (op)
         SEQ_INC:    upc_d = upc_inc;
         SEQ_JUMP:   upc_d = cr_addr;
         SEQ_BRANCH: upc_d = cond ? cr_addr : upc_inc;
         SEQ_DECODE: upc_d = decode_addr;
         SEQ_CALL: begin
            if (depth_q == DEPTH_MAX) begin
               fault_d = 1'b1;
               upc_d   = FAULT_STATE;
            end else begin
               push_en = 1'b1;
               depth_d = depth_q + 3'd1;
               upc_d   = cr_addr;
            end
         end
         SEQ_RET: begin
            if (depth_q == 3'd0) begin
               fault_d = 1'b1;
               upc_d   = FAULT_STATE;
            end else begin
               depth_d = depth_q - 3'd1;
               upc_d   = stack_mem[top_idx];
            end
         end
         SEQ_WAIT_MEM: begin
            if (mem_done) begin
               upc_d = upc_inc;
            end else if (wait_cnt_q == CNT_MAX) begin
               fault_d = 1'b1;
               upc_d   = FAULT_STATE;
            end else begin
               wait_cnt_d = wait_cnt_q + CW'(1);
            end
         end
         SEQ_FETCH:  upc_d = FETCH_STATE;
      endcase
   end

   // Sequencer state register with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         upc_q      <= FETCH_STATE;
         depth_q    <= 3'd0;
         wait_cnt_q <= '0;
         fault_q    <= 1'b0;
      end else begin
         upc_q      <= upc_d;
         depth_q    <= depth_d;
         wait_cnt_q <= wait_cnt_d;
         fault_q    <= fault_d;
      end
   end

   // Return-address storage; entries above the depth pointer are never read,
   // so the array itself needs no reset.
   always_ff @(posedge clk) begin
      if (push_en) begin
         stack_mem[push_idx] <= upc_inc;
      end
   end

endmodule

// File: tb/tb_microsequencer.sv
// Self-checking bench for microsequencer: a directed vector table, hand
// sequences for calls, waits, timeouts and reset, then random stimulus
// compared with a queue-based reference model.
module tb_microsequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] nsel = '0;
   logic [1:0] cond_sel = '0;
   logic       cond_inv = 1'b0;
   logic [9:0] cr_addr = '0;
   logic [9:0] decode_addr = '0;
   logic [3:0] flags = '0;
   logic       mem_done = 1'b0;
   logic [9:0] next_state;
   logic       mem_wait;
   logic [2:0] stack_depth;
   logic       fault;

   microsequencer dut (
      .clk(clk), .reset(reset), .nsel(nsel), .cond_sel(cond_sel),
      .cond_inv(cond_inv), .cr_addr(cr_addr), .decode_addr(decode_addr),
      .flags(flags), .mem_done(mem_done), .next_state(next_state),
      .mem_wait(mem_wait), .stack_depth(stack_depth), .fault(fault)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   // Reference model state: plain integers and a queue as the stack.
   int m_upc;
   int m_stack[$];
   int m_low;
   bit m_fault;

   typedef struct {
      logic [2:0] n;
      logic [1:0] cs;
      logic       ci;
      logic [9:0] cr;
      logic [9:0] da;
      logic [3:0] fl;
      logic       md;
      int         e_upc;
      int         e_depth;
      int         e_fault;
   } vec_t;

   vec_t vecs[$];

   task automatic checkOutput(input string name, input int actual, input int expected);
      total++;
      if (actual != expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   function automatic void model_reset();
      m_upc = 0;
      m_stack.delete();
      m_low = 0;
      m_fault = 0;
   endfunction

   function automatic void model_fault();
      m_fault = 1;
      m_upc = 255;
      m_low = 0;
   endfunction

   function automatic void model_step(input int n, input int cs, input int ci, input int cr,
                                      input int da, input logic [3:0] fl, input int md);
      int f;
      int c;
      int inc;
      inc = (m_upc + 1) % 1024;
      f = (cs == 0) ? 1 : int'(fl[cs - 1]);
      c = f ^ ci;
      if (n != 6) m_low = 0;
      case (n)
         0: m_upc = inc;
         1: m_upc = cr;
         2: m_upc = (c != 0) ? cr : inc;
         3: m_upc = da;
         4: if (m_stack.size() == 4) model_fault();
            else begin m_stack.push_back(inc); m_upc = cr; end
         5: if (m_stack.size() == 0) model_fault();
            else m_upc = m_stack.pop_back();
         6: if (md != 0) begin m_upc = inc; m_low = 0; end
            else begin
               m_low++;
               if (m_low > 15) model_fault();
            end
         default: m_upc = 0;
      endcase
   endfunction

   task automatic check_model();
      checkOutput("model next_state", int'(next_state), m_upc);
      checkOutput("model stack_depth", int'(stack_depth), m_stack.size());
      checkOutput("model fault", int'(fault), int'(m_fault));
   endtask

   // Drive one control word, check the combinational wait flag, clock it in
   // and compare the registered state with the model.
   task automatic applyStimulus(input logic [2:0] n, input logic [1:0] cs, input logic ci,
                                input logic [9:0] cr, input logic [9:0] da,
                                input logic [3:0] fl, input logic md);
      nsel = n; cond_sel = cs; cond_inv = ci; cr_addr = cr;
      decode_addr = da; flags = fl; mem_done = md;
      #1;
      checkOutput("mem_wait", int'(mem_wait), (n == 3'd6 && !md) ? 1 : 0);
      model_step(int'(n), int'(cs), int'(ci), int'(cr), int'(da), fl, int'(md));
      @(posedge clk);
      #1;
      check_model();
   endtask

   task automatic do_reset();
      reset = 1'b0;
      #2;
      model_reset();
      checkOutput("reset next_state", int'(next_state), 0);
      checkOutput("reset stack_depth", int'(stack_depth), 0);
      checkOutput("reset fault", int'(fault), 0);
      #2;
      reset = 1'b1;
   endtask

   task automatic jump_to(input logic [9:0] a);
      applyStimulus(3'd1, 2'd0, 1'b0, a, 10'd0, 4'd0, 1'b0);
   endtask

   task automatic add_vec(input logic [2:0] n, input logic [1:0] cs, input logic ci,
                          input logic [9:0] cr, input logic [9:0] da, input logic [3:0] fl,
                          input logic md, input int eu, input int ed, input int ef);
      vec_t v;
      v.n = n; v.cs = cs; v.ci = ci; v.cr = cr; v.da = da; v.fl = fl; v.md = md;
      v.e_upc = eu; v.e_depth = ed; v.e_fault = ef;
      vecs.push_back(v);
   endtask

   initial begin
      // Directed vectors, applied from a freshly reset sequencer at uPC 0.
      add_vec(3'd0, 2'd0, 1'b0, 10'd0,    10'd0,  4'b0000, 1'b0, 1,    0, 0);
      add_vec(3'd0, 2'd0, 1'b0, 10'd0,    10'd0,  4'b0000, 1'b0, 2,    0, 0);
      add_vec(3'd3, 2'd0, 1'b0, 10'd0,    10'd20, 4'b0000, 1'b0, 20,   0, 0);
      add_vec(3'd1, 2'd0, 1'b0, 10'd42,   10'd0,  4'b0000, 1'b0, 42,   0, 0);
      add_vec(3'd2, 2'd1, 1'b0, 10'd43,   10'd0,  4'b0001, 1'b0, 43,   0, 0);
      add_vec(3'd1, 2'd0, 1'b0, 10'd42,   10'd0,  4'b0000, 1'b0, 42,   0, 0);
      add_vec(3'd2, 2'd1, 1'b0, 10'd100,  10'd0,  4'b0000, 1'b0, 43,   0, 0);
      add_vec(3'd1, 2'd0, 1'b0, 10'd42,   10'd0,  4'b0000, 1'b0, 42,   0, 0);
      add_vec(3'd2, 2'd1, 1'b1, 10'd100,  10'd0,  4'b0001, 1'b0, 43,   0, 0);
      add_vec(3'd1, 2'd0, 1'b0, 10'd42,   10'd0,  4'b0000, 1'b0, 42,   0, 0);
      add_vec(3'd2, 2'd1, 1'b1, 10'd100,  10'd0,  4'b0000, 1'b0, 100,  0, 0);
      add_vec(3'd2, 2'd2, 1'b0, 10'd200,  10'd0,  4'b0010, 1'b0, 200,  0, 0);
      add_vec(3'd2, 2'd3, 1'b0, 10'd300,  10'd0,  4'b1011, 1'b0, 201,  0, 0);
      add_vec(3'd2, 2'd3, 1'b0, 10'd300,  10'd0,  4'b0100, 1'b0, 300,  0, 0);
      add_vec(3'd2, 2'd0, 1'b0, 10'd500,  10'd0,  4'b0000, 1'b0, 500,  0, 0);
      add_vec(3'd1, 2'd0, 1'b0, 10'd10,   10'd0,  4'b0000, 1'b0, 10,   0, 0);
      add_vec(3'd4, 2'd0, 1'b0, 10'd100,  10'd0,  4'b0000, 1'b0, 100,  1, 0);
      add_vec(3'd5, 2'd0, 1'b0, 10'd0,    10'd0,  4'b0000, 1'b0, 11,   0, 0);
      add_vec(3'd1, 2'd0, 1'b0, 10'd1023, 10'd0,  4'b0000, 1'b0, 1023, 0, 0);
      add_vec(3'd0, 2'd0, 1'b0, 10'd0,    10'd0,  4'b0000, 1'b0, 0,    0, 0);
      add_vec(3'd1, 2'd0, 1'b0, 10'd77,   10'd0,  4'b0000, 1'b0, 77,   0, 0);
      add_vec(3'd7, 2'd0, 1'b0, 10'd500,  10'd9,  4'b0000, 1'b0, 0,    0, 0);
      add_vec(3'd1, 2'd0, 1'b0, 10'd3,    10'd0,  4'b0000, 1'b0, 3,    0, 0);
      add_vec(3'd6, 2'd0, 1'b0, 10'd0,    10'd0,  4'b0000, 1'b1, 4,    0, 0);

      #2;
      do_reset();

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].n, vecs[i].cs, vecs[i].ci, vecs[i].cr,
                       vecs[i].da, vecs[i].fl, vecs[i].md);
         checkOutput($sformatf("vec%0d next_state", i), int'(next_state), vecs[i].e_upc);
         checkOutput($sformatf("vec%0d stack_depth", i), int'(stack_depth), vecs[i].e_depth);
         checkOutput($sformatf("vec%0d fault", i), int'(fault), vecs[i].e_fault);
      end

      // Memory wait: five low cycles hold uPC 3, then completion advances.
      jump_to(10'd3);
      for (int i = 0; i < 5; i++) begin
         nsel = 3'd6; mem_done = 1'b0;
         #1;
         checkOutput("wait hold mem_wait", int'(mem_wait), 1);
         applyStimulus(3'd6, 2'd0, 1'b0, 10'd0, 10'd0, 4'd0, 1'b0);
         checkOutput("wait hold next_state", int'(next_state), 3);
      end
      applyStimulus(3'd6, 2'd0, 1'b0, 10'd0, 10'd0, 4'd0, 1'b1);
      checkOutput("wait done next_state", int'(next_state), 4);

      // Watchdog: the sixteenth consecutive low cycle faults.
      jump_to(10'd3);
      for (int i = 0; i < 16; i++) begin
         applyStimulus(3'd6, 2'd0, 1'b0, 10'd0, 10'd0, 4'd0, 1'b0);
         checkOutput("timeout next_state", int'(next_state), (i < 15) ? 3 : 255);
         checkOutput("timeout fault", int'(fault), (i < 15) ? 0 : 1);
      end
      applyStimulus(3'd0, 2'd0, 1'b0, 10'd0, 10'd0, 4'd0, 1'b0);
      checkOutput("post-fault inc", int'(next_state), 256);
      checkOutput("post-fault sticky", int'(fault), 1);

      // Nested calls: four fit, the fifth overflows, then unwind exactly.
      do_reset();
      jump_to(10'd10);
      for (int i = 1; i <= 4; i++) begin
         applyStimulus(3'd4, 2'd0, 1'b0, 10'(i * 100), 10'd0, 4'd0, 1'b0);
         checkOutput("call next_state", int'(next_state), i * 100);
         checkOutput("call depth", int'(stack_depth), i);
      end
      applyStimulus(3'd4, 2'd0, 1'b0, 10'd500, 10'd0, 4'd0, 1'b0);
      checkOutput("overflow next_state", int'(next_state), 255);
      checkOutput("overflow fault", int'(fault), 1);
      checkOutput("overflow depth", int'(stack_depth), 4);
      for (int i = 3; i >= 0; i--) begin
         applyStimulus(3'd5, 2'd0, 1'b0, 10'd0, 10'd0, 4'd0, 1'b0);
         checkOutput("ret next_state", int'(next_state), (i == 0) ? 11 : i * 100 + 1);
         checkOutput("ret depth", int'(stack_depth), i);
      end

      // Underflow from a clean state.
      do_reset();
      applyStimulus(3'd5, 2'd0, 1'b0, 10'd0, 10'd0, 4'd0, 1'b0);
      checkOutput("underflow next_state", int'(next_state), 255);
      checkOutput("underflow fault", int'(fault), 1);

      // Reset in the middle of a memory wait with two return addresses held.
      do_reset();
      jump_to(10'd10);
      applyStimulus(3'd4, 2'd0, 1'b0, 10'd100, 10'd0, 4'd0, 1'b0);
      applyStimulus(3'd4, 2'd0, 1'b0, 10'd200, 10'd0, 4'd0, 1'b0);
      applyStimulus(3'd6, 2'd0, 1'b0, 10'd0, 10'd0, 4'd0, 1'b0);
      applyStimulus(3'd6, 2'd0, 1'b0, 10'd0, 10'd0, 4'd0, 1'b0);
      checkOutput("pre-reset depth", int'(stack_depth), 2);
      do_reset();

      // Random control words against the reference model.
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 79) == 0) begin
            do_reset();
         end else begin
            applyStimulus(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)), 10'($urandom), 10'($urandom),
                          4'($urandom), ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
